// File: rtl/cam_pkg.sv
// Shared types and constants for the cam_ctrl frame sequencer: state encoding,
// exposure clamp limits and the clamp helper.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    READ1,
    READ2,
    DONE
  } cam_state_t;

  localparam int EXP_MIN     = 2;
  localparam int EXP_MAX     = 30;
  localparam int EXP_DEFAULT = 15;
  localparam int CNT_W       = 16;

  // Out-of-range exposure requests fall back to a safe mid-range value.
  function automatic int exp_clamp(input int v);
    return ((v < EXP_MIN) || (v > EXP_MAX)) ? EXP_DEFAULT : v;
  endfunction

endpackage

// File: rtl/cam_timer.sv
// Loadable down-counter with terminal-count flag; the next count is exported so
// the sequencer can register its outputs in phase with the state.
module cam_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load)
      w_cnt_nxt = i_val;
    else if (r_cnt != '0)
      w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_tc      = (r_cnt == '0);

endmodule

// File: rtl/cam_ctrl.sv
// Pixel-array frame sequencer (erase, expose, two-row readout) with idle-gated
// exposure buttons. Optional macro CAM_CONTINUOUS_EN adds the cont input.
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int EXP_W        = 5,
  parameter int ERASE_CYCLES = 2,
  parameter int ADC_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
`ifdef CAM_CONTINUOUS_EN
  input  logic             cont,
`endif
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic [EXP_W-1:0] exp_time,
  output logic             exp_inc,
  output logic             exp_dec,
  output logic             erase,
  output logic             expose,
  output logic             nre_1,
  output logic             nre_2,
  output logic             adc,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] L_ERASE = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_READ  = CNT_W'(ADC_CYCLES + 1);

  cam_state_t       r_state;
  cam_state_t       w_state_nxt;
  logic [EXP_W-1:0] r_exp;
  logic [EXP_W-1:0] w_exp_clamped;
  logic             r_btn_inc_q;
  logic             r_btn_dec_q;
  logic             w_load;
  logic             w_latch;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_tc;
  logic             w_inc_rise;
  logic             w_dec_rise;
  logic             w_in_row;

  cam_timer #(.CW(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_val    (w_load_val),
    .o_cnt_nxt(w_cnt_nxt),
    .o_tc     (w_tc)
  );

  assign w_exp_clamped = EXP_W'(exp_clamp(int'(exp_time)));
  assign w_inc_rise    = btn_inc & ~r_btn_inc_q;
  assign w_dec_rise    = btn_dec & ~r_btn_dec_q;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: if (init) begin
        w_state_nxt = ERASE;
        w_load      = 1'b1;
        w_load_val  = L_ERASE;
        w_latch     = 1'b1;
      end
      ERASE: if (w_tc) begin
        w_state_nxt = EXPOSE;
        w_load      = 1'b1;
        w_load_val  = CNT_W'(r_exp) - CNT_W'(1);
      end
      EXPOSE: if (w_tc) begin
        w_state_nxt = READ1;
        w_load      = 1'b1;
        w_load_val  = L_READ;
      end
      READ1: if (w_tc) begin
        w_state_nxt = READ2;
        w_load      = 1'b1;
        w_load_val  = L_READ;
      end
      READ2: if (w_tc) w_state_nxt = DONE;
      DONE: begin
        w_state_nxt = IDLE;
`ifdef CAM_CONTINUOUS_EN
        if (cont) begin
          w_state_nxt = ERASE;
          w_load      = 1'b1;
          w_load_val  = L_ERASE;
          w_latch     = 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Row sub-cycle: first and last are settle slots, the middle ADC_CYCLES strobe.
  assign w_in_row = (w_state_nxt == READ1) || (w_state_nxt == READ2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_btn_inc_q <= 1'b0;
      r_btn_dec_q <= 1'b0;
      exp_inc     <= 1'b0;
      exp_dec     <= 1'b0;
      erase       <= 1'b0;
      expose      <= 1'b0;
      nre_1       <= 1'b1;
      nre_2       <= 1'b1;
      adc         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_inc_q <= btn_inc;
      r_btn_dec_q <= btn_dec;
      exp_inc     <= w_inc_rise && (r_state == IDLE);
      exp_dec     <= w_dec_rise && !w_inc_rise && (r_state == IDLE);
      erase       <= (w_state_nxt == ERASE);
      expose      <= (w_state_nxt == EXPOSE);
      nre_1       <= (w_state_nxt != READ1);
      nre_2       <= (w_state_nxt != READ2);
      adc         <= w_in_row && (w_cnt_nxt != '0) && (w_cnt_nxt != L_READ);
      busy        <= (w_state_nxt != IDLE);
      frame_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_latch)
      r_exp <= w_exp_clamped;
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: directed scenarios plus randomized traffic
// against a frame-timeline reference model.
module tb_cam_ctrl;

  localparam int E = 2;
  localparam int A = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [4:0] exp_time = 5'd15;
  logic       exp_inc, exp_dec, erase, expose, nre_1, nre_2, adc, busy, frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: t = cycles since the accepting init edge (0 = idle).
  int   m_t = 0;
  int   m_x = 15;
  logic m_pi = 1'b0, m_pd = 1'b0, m_inc = 1'b0, m_dec = 1'b0;

  logic [8:0] got, want;

  cam_ctrl #(.EXP_W(5), .ERASE_CYCLES(E), .ADC_CYCLES(A)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
`ifdef CAM_CONTINUOUS_EN
    .cont      (1'b0),
`endif
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .exp_time  (exp_time),
    .exp_inc   (exp_inc),
    .exp_dec   (exp_dec),
    .erase     (erase),
    .expose    (expose),
    .nre_1     (nre_1),
    .nre_2     (nre_2),
    .adc       (adc),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int clampx(input int v);
    return (v < 2 || v > 30) ? 15 : v;
  endfunction

  function automatic int frame_len(input int x);
    return E + x + 2 * (A + 2) + 1;
  endfunction

  function automatic logic [8:0] model_out();
    int r1, r2, dn;
    logic e, x, n1, n2, a, b, fd;
    r1 = E + m_x + 1;
    r2 = r1 + A + 2;
    dn = r2 + A + 2;
    e  = (m_t >= 1) && (m_t <= E);
    x  = (m_t > E) && (m_t <= E + m_x);
    n1 = !((m_t >= r1) && (m_t < r2));
    n2 = !((m_t >= r2) && (m_t < dn));
    a  = ((m_t >= r1 + 1) && (m_t <= r1 + A)) || ((m_t >= r2 + 1) && (m_t <= r2 + A));
    b  = (m_t != 0);
    fd = (m_t == dn);
    return {e, x, n1, n2, a, b, fd, m_inc, m_dec};
  endfunction

  task automatic advance(input logic r, input logic i, input logic bi, input logic bd,
                         input logic [4:0] et);
    logic ri, rd;
    @(negedge clk);
    reset = r; init = i; btn_inc = bi; btn_dec = bd; exp_time = et;
    @(posedge clk);
    if (r) begin
      m_t = 0; m_pi = 1'b0; m_pd = 1'b0; m_inc = 1'b0; m_dec = 1'b0;
    end else begin
      ri    = bi & ~m_pi;
      rd    = bd & ~m_pd;
      m_inc = ri && (m_t == 0);
      m_dec = rd && !ri && (m_t == 0);
      m_pi  = bi;
      m_pd  = bd;
      if (m_t == 0) begin
        if (i) begin
          m_t = 1;
          m_x = clampx(int'(et));
        end
      end else if (m_t == frame_len(m_x)) begin
        m_t = 0;
      end else begin
        m_t++;
      end
    end
    #1;
    got = {erase, expose, nre_1, nre_2, adc, busy, frame_done, exp_inc, exp_dec};
    want = model_out();
  endtask

  task automatic test_reset();
    advance(1'b1, 1'b0, 1'b0, 1'b0, 5'd15);
    advance(1'b1, 1'b1, 1'b1, 1'b1, 5'd15);
    checks++;
    if (got !== 9'b0_0_1_1_0_0_0_0_0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", got, 9'b0_0_1_1_0_0_0_0_0);
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
  endtask

  task automatic test_frame_default();
    int done_cyc = -1, idle_cyc = -1, adc_cnt = 0;
    for (int c = 1; c <= 34; c++) begin
      advance(1'b0, c == 1, 1'b0, 1'b0, 5'd15);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL frame_default cyc=%0d got=%b want=%b", c, got, want);
      end
      if (frame_done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (busy === 1'b0 && c > 1 && idle_cyc < 0) idle_cyc = c;
      if (adc === 1'b1) adc_cnt++;
    end
    checks++;
    if (done_cyc !== 30) begin
      errors++;
      $display("FAIL frame_done_cycle got=%0d want=30", done_cyc);
    end
    checks++;
    if (idle_cyc !== 31) begin
      errors++;
      $display("FAIL busy_low_cycle got=%0d want=31", idle_cyc);
    end
    checks++;
    if (adc_cnt !== 2 * A) begin
      errors++;
      $display("FAIL adc_strobe_count got=%0d want=%0d", adc_cnt, 2 * A);
    end
  endtask

  task automatic test_clamp();
    int vals[5] = '{1, 31, 2, 30, 0};
    int reqd[5] = '{15, 15, 2, 30, 15};
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      for (int c = 1; c <= 50; c++) begin
        advance(1'b0, c == 1, 1'b0, 1'b0, (c == 1) ? 5'(vals[k]) : 5'(c));
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL clamp_trace exp=%0d cyc=%0d got=%b want=%b", vals[k], c, got, want);
        end
        if (expose === 1'b1) n++;
      end
      checks++;
      if (n !== reqd[k]) begin
        errors++;
        $display("FAIL clamp_len exp_time=%0d got=%0d want=%0d", vals[k], n, reqd[k]);
      end
    end
  endtask

  task automatic test_buttons();
    int dec_pulses = 0;
    advance(1'b0, 1'b0, 1'b1, 1'b0, 5'd15);
    checks++;
    if ({exp_inc, exp_dec} !== 2'b10) begin
      errors++;
      $display("FAIL btn_inc_idle got=%b want=10", {exp_inc, exp_dec});
    end
    advance(1'b0, 1'b0, 1'b1, 1'b0, 5'd15);
    checks++;
    if ({exp_inc, exp_dec} !== 2'b00) begin
      errors++;
      $display("FAIL btn_inc_held got=%b want=00", {exp_inc, exp_dec});
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
    advance(1'b0, 1'b0, 1'b1, 1'b1, 5'd15);
    checks++;
    if ({exp_inc, exp_dec} !== 2'b10) begin
      errors++;
      $display("FAIL btn_both got=%b want=10", {exp_inc, exp_dec});
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
    advance(1'b0, 1'b0, 1'b0, 1'b1, 5'd15);
    checks++;
    if ({exp_inc, exp_dec} !== 2'b01) begin
      errors++;
      $display("FAIL btn_dec_idle got=%b want=01", {exp_inc, exp_dec});
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
    for (int c = 1; c <= 40; c++) begin
      advance(1'b0, c == 1, 1'b0, c >= 6, 5'd15);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL btn_busy_trace cyc=%0d got=%b want=%b", c, got, want);
      end
      if (exp_dec === 1'b1) dec_pulses++;
    end
    checks++;
    if (dec_pulses !== 0) begin
      errors++;
      $display("FAIL btn_dec_busy_held got=%0d pulses want=0", dec_pulses);
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
  endtask

  task automatic test_reset_midframe();
    int done_cnt = 0;
    advance(1'b0, 1'b1, 1'b0, 1'b0, 5'd15);
    for (int c = 2; c <= 20; c++) advance(1'b0, c == 10, 1'b0, 1'b0, 5'd15);
    checks++;
    if (nre_1 !== 1'b0) begin
      errors++;
      $display("FAIL in_read1 nre_1 got=%b want=0", nre_1);
    end
    advance(1'b1, 1'b0, 1'b0, 1'b0, 5'd15);
    checks++;
    if ({nre_1, adc, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_read1 {nre_1,adc,busy} got=%b want=100", {nre_1, adc, busy});
    end
    advance(1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_resume busy got=%b want=0", busy);
    end
    // One frame with a stray init during EXPOSE.
    for (int c = 1; c <= 45; c++) begin
      advance(1'b0, (c == 1) || (c == 8), 1'b0, 1'b0, 5'd15);
      if (frame_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL init_while_busy frames got=%0d want=1", done_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      advance($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              ($urandom_range(0, 3) == 0) ? ~btn_inc : btn_inc,
              ($urandom_range(0, 3) == 0) ? ~btn_dec : btn_dec,
              5'($urandom_range(0, 31)));
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random cyc=%0d t=%0d got=%b want=%b", c, m_t, got, want);
      end
      checks++;
      if (($countones({erase, expose, ~nre_1, ~nre_2})) > 1) begin
        errors++;
        $display("FAIL exclusive_phase cyc=%0d got=%b want=onehot0", c,
                 {erase, expose, ~nre_1, ~nre_2});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_default();
    test_clamp();
    test_buttons();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
